// File: rtl/upstream_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : upstream_order_arbiter
// Description : Round-robin arbiter that serialises order and max-update
//               requests onto the shared upstream risk cache, performing an
//               atomic read / risk-check / write-back per transaction.
//               Optional cache watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module upstream_order_arbiter #(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic [NPORTS-1:0]     req_valid,
    output logic [NPORTS-1:0]     req_ready,
    input  logic [5*NPORTS-1:0]   req_client_id,
    input  logic [16*NPORTS-1:0]  req_amount,
    input  logic [NPORTS-1:0]     req_new_max,
    input  logic [15:0]           cancelled_orders,
    output logic                  cache_req_valid,
    output logic                  cache_req_rw,
    output logic [31:0]           cache_req_index,
    output logic [31:0]           cache_req_data,
    input  logic                  cache_res_ready,
    input  logic [31:0]           cache_res_data,
    output logic                  resp_valid,
    output logic [2:0]            resp_port,
    output logic                  resp_pass,
    output logic                  resp_error,
    input  logic                  resp_ready
);

    localparam int           PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [PW:0]  NP = (PW+1)'(NPORTS);

    if (NPORTS < 2 || NPORTS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("upstream_order_arbiter: NPORTS must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0] r_port, w_port_nxt;
    logic [4:0]    r_cid, w_cid_nxt;
    logic [15:0]   r_amount, w_amount_nxt;
    logic          r_new_max, w_new_max_nxt;
    logic [31:0]   r_entry, w_entry_nxt;

    logic          w_cache_valid_nxt, w_cache_rw_nxt;
    logic [31:0]   w_cache_index_nxt, w_cache_data_nxt;
    logic          w_resp_valid_nxt, w_resp_pass_nxt, w_resp_error_nxt;
    logic [2:0]    w_resp_port_nxt;

    logic [4:0]    w_cid  [NPORTS];
    logic [15:0]   w_amt  [NPORTS];
    for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
        assign w_cid[p] = req_client_id[5*p +: 5];
        assign w_amt[p] = req_amount[16*p +: 16];
    end

    // Search starts at rr_ptr and wraps modulo NPORTS (need not be a power of 2).
    logic          w_found;
    logic [PW-1:0] w_grant;
    logic [PW:0]   w_rr_inc;
    always_comb begin
        logic [PW:0] sum;
        sum     = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NPORTS; i++) begin
            sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (sum >= NP)
                sum = sum - NP;
            if (!w_found && req_valid[sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_grant = sum[PW-1:0];
            end
        end
        w_rr_inc = {1'b0, w_grant} + (PW+1)'(1);
        if (w_rr_inc >= NP)
            w_rr_inc = '0;
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found && HRESETn)
            req_ready[w_grant] = 1'b1;
    end

    // Unsigned operands widened to 17 bits so an over-cancelled total goes negative.
    logic [16:0] w_result;
    logic        w_order_pass;
    assign w_result     = {1'b0, r_entry[15:0]} - {1'b0, cancelled_orders} + {1'b0, r_amount};
    assign w_order_pass = $signed({1'b0, r_entry[31:16]}) > $signed(w_result);

    logic w_tmo;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn)
            r_tmo_cnt <= '0;
        else if (w_state_nxt != r_state)
            r_tmo_cnt <= '0;
        else if (r_state == S_READ || r_state == S_WRITE)
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    assign w_tmo = (r_state == S_READ || r_state == S_WRITE) && !cache_res_ready &&
                   (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_port_nxt        = r_port;
        w_cid_nxt         = r_cid;
        w_amount_nxt      = r_amount;
        w_new_max_nxt     = r_new_max;
        w_entry_nxt       = r_entry;
        w_cache_valid_nxt = cache_req_valid;
        w_cache_rw_nxt    = cache_req_rw;
        w_cache_index_nxt = cache_req_index;
        w_cache_data_nxt  = cache_req_data;
        w_resp_valid_nxt  = resp_valid;
        w_resp_port_nxt   = resp_port;
        w_resp_pass_nxt   = resp_pass;
        w_resp_error_nxt  = resp_error;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt       = S_READ;
                    w_port_nxt        = w_grant;
                    w_cid_nxt         = w_cid[w_grant];
                    w_amount_nxt      = w_amt[w_grant];
                    w_new_max_nxt     = req_new_max[w_grant];
                    w_rr_ptr_nxt      = w_rr_inc[PW-1:0];
                    w_cache_valid_nxt = 1'b1;
                    w_cache_rw_nxt    = 1'b0;
                    w_cache_index_nxt = {23'b0, w_cid[w_grant], 4'b0};
                    w_cache_data_nxt  = 32'b0;
                end
            end
            S_READ: begin
                if (cache_res_ready) begin
                    w_state_nxt       = S_CHECK;
                    w_entry_nxt       = cache_res_data;
                    w_cache_valid_nxt = 1'b0;
                    w_cache_index_nxt = 32'b0;
                end else if (w_tmo) begin
                    w_state_nxt       = S_RESP;
                    w_cache_valid_nxt = 1'b0;
                    w_cache_index_nxt = 32'b0;
                    w_resp_valid_nxt  = 1'b1;
                    w_resp_port_nxt   = 3'(r_port);
                    w_resp_pass_nxt   = 1'b0;
                    w_resp_error_nxt  = 1'b1;
                end
            end
            S_CHECK: begin
                if (r_new_max || w_order_pass) begin
                    w_state_nxt       = S_WRITE;
                    w_cache_valid_nxt = 1'b1;
                    w_cache_rw_nxt    = 1'b1;
                    w_cache_index_nxt = {23'b0, r_cid, 4'b0};
                    w_cache_data_nxt  = r_new_max ? {r_amount, r_entry[15:0]}
                                                  : {r_entry[31:16], w_result[15:0]};
                end else begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_port_nxt  = 3'(r_port);
                    w_resp_pass_nxt  = 1'b0;
                    w_resp_error_nxt = 1'b0;
                end
            end
            S_WRITE: begin
                if (cache_res_ready || w_tmo) begin
                    w_state_nxt       = S_RESP;
                    w_cache_valid_nxt = 1'b0;
                    w_cache_rw_nxt    = 1'b0;
                    w_cache_index_nxt = 32'b0;
                    w_cache_data_nxt  = 32'b0;
                    w_resp_valid_nxt  = 1'b1;
                    w_resp_port_nxt   = 3'(r_port);
                    w_resp_pass_nxt   = cache_res_ready;
                    w_resp_error_nxt  = !cache_res_ready;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_resp_port_nxt  = 3'b0;
                    w_resp_pass_nxt  = 1'b0;
                    w_resp_error_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_port          <= '0;
            r_cid           <= '0;
            r_amount        <= '0;
            r_new_max       <= 1'b0;
            r_entry         <= '0;
            cache_req_valid <= 1'b0;
            cache_req_rw    <= 1'b0;
            cache_req_index <= '0;
            cache_req_data  <= '0;
            resp_valid      <= 1'b0;
            resp_port       <= '0;
            resp_pass       <= 1'b0;
            resp_error      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_port          <= w_port_nxt;
            r_cid           <= w_cid_nxt;
            r_amount        <= w_amount_nxt;
            r_new_max       <= w_new_max_nxt;
            r_entry         <= w_entry_nxt;
            cache_req_valid <= w_cache_valid_nxt;
            cache_req_rw    <= w_cache_rw_nxt;
            cache_req_index <= w_cache_index_nxt;
            cache_req_data  <= w_cache_data_nxt;
            resp_valid      <= w_resp_valid_nxt;
            resp_port       <= w_resp_port_nxt;
            resp_pass       <= w_resp_pass_nxt;
            resp_error      <= w_resp_error_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upstream_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_upstream_order_arbiter
// Description : Directed self-checking bench for upstream_order_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upstream_order_arbiter;

    localparam int NPORTS = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 64;
`endif

    logic                 clk = 1'b0;
    logic                 HRESETn;
    logic [NPORTS-1:0]    req_valid;
    logic [NPORTS-1:0]    req_ready;
    logic [5*NPORTS-1:0]  req_client_id;
    logic [16*NPORTS-1:0] req_amount;
    logic [NPORTS-1:0]    req_new_max;
    logic [15:0]          cancelled_orders;
    logic                 cache_req_valid;
    logic                 cache_req_rw;
    logic [31:0]          cache_req_index;
    logic [31:0]          cache_req_data;
    logic                 cache_res_ready;
    logic [31:0]          cache_res_data;
    logic                 resp_valid;
    logic [2:0]           resp_port;
    logic                 resp_pass;
    logic                 resp_error;
    logic                 resp_ready;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    upstream_order_arbiter #(.NPORTS(NPORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .HRESETn          (HRESETn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_client_id    (req_client_id),
        .req_amount       (req_amount),
        .req_new_max      (req_new_max),
        .cancelled_orders (cancelled_orders),
        .cache_req_valid  (cache_req_valid),
        .cache_req_rw     (cache_req_rw),
        .cache_req_index  (cache_req_index),
        .cache_req_data   (cache_req_data),
        .cache_res_ready  (cache_res_ready),
        .cache_res_data   (cache_res_data),
        .resp_valid       (resp_valid),
        .resp_port        (resp_port),
        .resp_pass        (resp_pass),
        .resp_error       (resp_error),
        .resp_ready       (resp_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [4:0] cid, input logic [15:0] amt,
                            input logic nm);
        req_client_id[5*p +: 5]  = cid;
        req_amount[16*p +: 16]   = amt;
        req_new_max[p]           = nm;
    endtask

    initial begin
        HRESETn          = 1'b0;
        req_valid        = '0;
        req_client_id    = '0;
        req_amount       = '0;
        req_new_max      = '0;
        cancelled_orders = '0;
        cache_res_ready  = 1'b0;
        cache_res_data   = '0;
        resp_ready       = 1'b0;
        tick();
        tick();
        chk("rst_cache_valid", cache_req_valid, 0);
        chk("rst_cache_index", cache_req_index, 0);
        chk("rst_resp_valid",  resp_valid, 0);
        chk("rst_req_ready",   req_ready, 0);
        HRESETn = 1'b1;
        tick();

        // Port 1 order, client 3, amount 100: 200-50+100=250 < 500 -> pass, write back
        set_port(1, 5'd3, 16'd100, 1'b0);
        req_valid = 4'b0010;
        #1;
        chk("t1_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("t1_read_valid", cache_req_valid, 1);
        chk("t1_read_rw",    cache_req_rw, 0);
        chk("t1_read_index", cache_req_index, 32'h30);
        cache_res_ready  = 1'b1;
        cache_res_data   = 32'h01F4_00C8;
        cancelled_orders = 16'd50;
        tick();
        cache_res_ready = 1'b0;
        chk("t1_check_idle_bus", cache_req_valid, 0);
        tick();
        chk("t1_write_valid", cache_req_valid, 1);
        chk("t1_write_rw",    cache_req_rw, 1);
        chk("t1_write_index", cache_req_index, 32'h30);
        chk("t1_write_data",  cache_req_data, 32'h01F4_00FA);
        cache_res_ready = 1'b1;
        tick();
        cache_res_ready = 1'b0;
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_port",  resp_port, 1);
        chk("t1_resp_pass",  resp_pass, 1);
        chk("t1_bus_dropped", cache_req_valid, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t1_resp_done", resp_valid, 0);

        // Port 0 order, client 7: 150+300=450 not < 400 -> fail, response 3 cycles after grant
        cancelled_orders = 16'd0;
        set_port(0, 5'd7, 16'd300, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("t2_grant_wrap", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t2_read_index", cache_req_index, 32'h70);
        cache_res_ready = 1'b1;
        cache_res_data  = 32'h0190_0096;
        tick();
        cache_res_ready = 1'b0;
        tick();
        chk("t2_resp_valid", resp_valid, 1);
        chk("t2_no_write",   cache_req_valid, 0);
        chk("t2_resp_pass",  resp_pass, 0);
        chk("t2_resp_port",  resp_port, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Port 2 max-update, client 5, new max 1000; response held until resp_ready
        set_port(2, 5'd5, 16'd1000, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("t3_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("t3_read_index", cache_req_index, 32'h50);
        cache_res_ready = 1'b1;
        cache_res_data  = 32'h0064_0020;
        tick();
        cache_res_ready = 1'b0;
        tick();
        chk("t3_write_data", cache_req_data, 32'h03E8_0020);
        cache_res_ready = 1'b1;
        tick();
        cache_res_ready = 1'b0;
        tick();
        chk("t3_resp_hold",  resp_valid, 1);
        chk("t3_resp_port",  resp_port, 2);
        chk("t3_resp_pass",  resp_pass, 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Port 3 order with a stalled cache
        set_port(3, 5'd9, 16'd10, 1'b0);
        req_valid = 4'b1000;
        #1;
        chk("t4_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        cache_res_data = 32'h0;
`ifdef ARB_TIMEOUT_EN
        for (int n = 0; n < 7; n++) tick();
        chk("t4_no_early_abort", resp_valid, 0);
        tick();
        chk("t4_tmo_valid", resp_valid, 1);
        chk("t4_tmo_error", resp_error, 1);
        chk("t4_tmo_pass",  resp_pass, 0);
        chk("t4_tmo_bus",   cache_req_valid, 0);
`else
        for (int n = 0; n < 20; n++) tick();
        chk("t4_still_waiting", cache_req_valid, 1);
        chk("t4_no_resp",       resp_valid, 0);
        cache_res_ready = 1'b1;
        tick();
        cache_res_ready = 1'b0;
        tick();
        chk("t4_resp_valid", resp_valid, 1);
        chk("t4_resp_port",  resp_port, 3);
        chk("t4_resp_error", resp_error, 0);
`endif
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset asserted during WRITE
        set_port(0, 5'd1, 16'd5, 1'b1);
        req_valid = 4'b0001;
        #1;
        chk("t5_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        cache_res_ready = 1'b1;
        tick();
        cache_res_ready = 1'b0;
        tick();
        chk("t5_in_write", cache_req_rw, 1);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_valid", cache_req_valid, 0);
        chk("t5_rst_rw",    cache_req_rw, 0);
        chk("t5_rst_index", cache_req_index, 0);
        chk("t5_rst_data",  cache_req_data, 0);
        chk("t5_rst_resp",  resp_valid, 0);
        tick();
        HRESETn = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        chk("t5_no_stale_resp", resp_valid, 0);
        chk("t5_no_stale_bus",  cache_req_valid, 0);

        // All ports valid continuously, instant cache: rotation restarts at port 0
        for (int p = 0; p < NPORTS; p++) set_port(p, 5'(p + 10), 16'd1, 1'b1);
        req_valid       = 4'b1111;
        cache_res_ready = 1'b1;
        resp_ready      = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            int         n;
            e = 4'b0001 << (k % 4);
            n = 0;
            while (req_ready == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("t6_grant%0d", k), req_ready, e);
            tick();
        end
        req_valid = '0;
        for (int n = 0; n < 6; n++) tick();
        chk("t6_drained", resp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
